// File: rtl/pim_lut_search_engine_if.sv
// Stream bundle for pim_lut_search_engine: offset load, LUT burst input, result beat output.
// Optional statistics signals exist only when PIM_LUT_STAT_EN is defined.
interface pim_lut_search_engine_if #(
  parameter int NUM_ACC    = 16,
  parameter int DATA_W     = 16,
  parameter int ENTRIES    = 16,
  parameter int NUM_BURSTS = 4,
  parameter int LANES      = 4
);
  localparam int ENT_W = $clog2(ENTRIES);
  localparam int BID_W = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
  localparam int OFF_W = ENT_W + BID_W;

  logic                        i_off_load;
  logic [NUM_ACC*OFF_W-1:0]    i_acc_offset;
  logic                        i_lut_valid;
  logic                        o_lut_ready;
  logic [BID_W-1:0]            i_lut_bid;
  logic [ENTRIES*DATA_W-1:0]   i_lut_data;
  logic                        o_res_valid;
  logic                        i_res_ready;
  logic [LANES*DATA_W-1:0]     o_res_data;
  logic [NUM_ACC-1:0]          o_res_enable;
  logic                        o_busy;
  logic                        o_done;
`ifdef PIM_LUT_STAT_EN
  logic [15:0]                 o_stat_bursts;
  logic [15:0]                 o_stat_drops;
`endif

  modport slave (
    input  i_off_load, i_acc_offset, i_lut_valid, i_lut_bid, i_lut_data, i_res_ready,
    output o_lut_ready, o_res_valid, o_res_data, o_res_enable, o_busy, o_done
`ifdef PIM_LUT_STAT_EN
    , output o_stat_bursts, o_stat_drops
`endif
  );

  modport master (
    output i_off_load, i_acc_offset, i_lut_valid, i_lut_bid, i_lut_data, i_res_ready,
    input  o_lut_ready, o_res_valid, o_res_data, o_res_enable, o_busy, o_done
`ifdef PIM_LUT_STAT_EN
    , input o_stat_bursts, o_stat_drops
`endif
  );
endinterface

// File: rtl/pim_lut_search_engine.sv
// LUT lookup engine: resolves one LUT entry per accumulator from tagged bursts, LANES per beat.
// Define PIM_LUT_STAT_EN to add saturating accepted-burst / dropped-burst counters.
module pim_lut_search_engine #(
  parameter int NUM_ACC    = 16,
  parameter int DATA_W     = 16,
  parameter int ENTRIES    = 16,
  parameter int NUM_BURSTS = 4,
  parameter int LANES      = 4
) (
  input logic                     clk,
  input logic                     rst_x,
  pim_lut_search_engine_if.slave  bus
);
  localparam int ENT_W = $clog2(ENTRIES);
  localparam int BID_W = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
  localparam int OFF_W = ENT_W + BID_W;
  localparam int NGRP  = NUM_ACC / LANES;
  localparam int GRP_W = (NGRP > 1) ? $clog2(NGRP) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SCAN, S_DRAIN} state_t;

  state_t                     state_q, state_d;
  logic [NUM_ACC*OFF_W-1:0]   off_q;
  logic [NUM_ACC-1:0]         pending_q, pending_d;
  logic [NUM_ACC-1:0]         hit_q, new_hit, grp_sel, beat_en;
  logic [ENTRIES*DATA_W-1:0]  burst_q;
  logic [GRP_W-1:0]           grp_q, grp_d;
  logic                       res_valid_q;
  logic [LANES*DATA_W-1:0]    res_data_q, lane_data;
  logic [NUM_ACC-1:0]         res_enable_q;
  logic [LANES-1:0]           grp_hit;
  logic                       out_free, load_off, accept_burst, load_beat, done;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ACC; gi++) begin : g_acc
      assign new_hit[gi] = pending_q[gi] &
                           (off_q[gi*OFF_W+ENT_W +: BID_W] == bus.i_lut_bid);
      assign grp_sel[gi] = ((gi / LANES) == int'(grp_q));
    end
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [ENT_W-1:0] entry;
      assign entry = off_q[(int'(grp_q)*LANES + gi)*OFF_W +: ENT_W];
      assign lane_data[gi*DATA_W +: DATA_W] =
          grp_hit[gi] ? burst_q[int'(entry)*DATA_W +: DATA_W] : '0;
    end
  endgenerate

  assign beat_en  = hit_q & grp_sel;
  assign grp_hit  = hit_q[int'(grp_q)*LANES +: LANES];
  assign out_free = !res_valid_q || bus.i_res_ready;

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    grp_d        = grp_q;
    load_off     = 1'b0;
    accept_burst = 1'b0;
    load_beat    = 1'b0;
    done         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.i_off_load) begin
          load_off  = 1'b1;
          pending_d = '1;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.i_lut_valid) begin
          accept_burst = 1'b1;
          if (|new_hit) begin
            state_d = S_SCAN;
            grp_d   = '0;
          end
        end
      end
      S_SCAN: begin
        // Empty groups advance freely; populated ones wait for the output register.
        if (!(|grp_hit) || out_free) begin
          load_beat = |grp_hit;
          if (load_beat) pending_d = pending_q & ~beat_en;
          if (grp_q == GRP_W'(NGRP-1)) begin
            grp_d   = '0;
            state_d = (pending_d == '0) ? S_DRAIN : S_WAIT;
          end else begin
            grp_d = grp_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (!res_valid_q) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      state_q      <= S_IDLE;
      off_q        <= '0;
      pending_q    <= '0;
      hit_q        <= '0;
      burst_q      <= '0;
      grp_q        <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_enable_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      grp_q     <= grp_d;
      if (load_off) off_q <= bus.i_acc_offset;
      if (accept_burst) begin
        burst_q <= bus.i_lut_data;
        hit_q   <= new_hit;
      end
      if (load_beat) begin
        res_valid_q  <= 1'b1;
        res_data_q   <= lane_data;
        res_enable_q <= beat_en;
      end else if (bus.i_res_ready) begin
        res_valid_q <= 1'b0;
      end
    end
  end

  assign bus.o_lut_ready  = (state_q == S_WAIT);
  assign bus.o_res_valid  = res_valid_q;
  assign bus.o_res_data   = res_data_q;
  assign bus.o_res_enable = res_enable_q;
  assign bus.o_busy       = (state_q != S_IDLE);
  assign bus.o_done       = done;

`ifdef PIM_LUT_STAT_EN
  logic [15:0] stat_bursts_q, stat_drops_q;

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      stat_bursts_q <= '0;
      stat_drops_q  <= '0;
    end else if (load_off) begin
      stat_bursts_q <= '0;
      stat_drops_q  <= '0;
    end else if (accept_burst) begin
      if (stat_bursts_q != 16'hFFFF) stat_bursts_q <= stat_bursts_q + 16'd1;
      if (!(|new_hit) && (stat_drops_q != 16'hFFFF)) stat_drops_q <= stat_drops_q + 16'd1;
    end
  end

  assign bus.o_stat_bursts = stat_bursts_q;
  assign bus.o_stat_drops  = stat_drops_q;
`endif
endmodule
